id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage feeding the ALU.
//  - Captures decoded instruction fields once per cycle.
//  - Resolves EX-stage forwarding from the MEM and WB stages.
//  - Drives the ALU operand and control inputs.
//  - Detects load-use hazards and inserts a bubble, so the ALU always sees current operands.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register address width
//  ALUC_W   5   ALU control width
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       async active-low reset
//  stall           in   1       downstream hold; stage keeps its contents
//  flush           in   1       kill the instruction entering EX (branch/jump redirect)
//  id_valid        in   1       decode holds a real instruction
//  id_pc           in   XLEN    PC of the decoded instruction
//  id_rs1_data     in   XLEN    register-file read port 1
//  id_rs2_data     in   XLEN    register-file read port 2
//  id_imm          in   XLEN    sign-extended immediate
//  id_rs1_addr     in   REG_AW  source register 1
//  id_rs2_addr     in   REG_AW  source register 2
//  id_rd_addr      in   REG_AW  destination register
//  id_alu_control  in   ALUC_W  ALU op code
//  id_alu_src      in   1       1 = ALU operand B is the immediate
//  id_reg_write    in   1       writes rd
//  id_mem_read     in   1       load
//  id_mem_write    in   1       store
//  mem_reg_write   in   1       MEM stage will write (already valid-qualified)
//  mem_rd_addr     in   REG_AW  MEM stage destination
//  mem_result      in   XLEN    MEM stage ALU result
//  wb_reg_write    in   1       WB stage writes (already valid-qualified)
//  wb_rd_addr      in   REG_AW  WB stage destination
//  wb_result       in   XLEN    WB stage write data
//  load_use_stall  out  1       combinational; fetch/decode must hold
//  ex_valid        out  1       EX holds a real instruction
//  ex_pc           out  XLEN    registered PC
//  alu_rs1         out  XLEN    ALU operand A (forwarded)
//  alu_rs2         out  XLEN    ALU operand B (immediate or forwarded rs2)
//  alu_control     out  ALUC_W  registered ALU op
//  ex_store_data   out  XLEN    forwarded rs2 for stores
//  ex_rd_addr      out  REG_AW  registered rd
//  ex_reg_write    out  1       registered, gated by valid
//  ex_mem_read     out  1       registered, gated by valid
//  ex_mem_write    out  1       registered, gated by valid
// BEHAVIOUR
//  Reset
//  - Every register and output goes to 0 asynchronously when rst_n=0.
//  Latency
//  - id_* inputs appear on ex_* one clock after capture.
//  - alu_rs1, alu_rs2 and ex_store_data are combinational from the registers and forwarding inputs.
//  Per-edge update priority: flush > stall > bubble > load
//  - flush: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write go to 0. This overrides stall.
//  - stall: all fields hold, except the rs1/rs2 data registers, which reload with their forwarded
//    values. A value written by WB during the hold is therefore kept.
//  - bubble (load_use_stall=1): load a bubble with valid=0 and all write/mem controls 0.
//  - load: capture all id_* fields. Controls are ANDed with id_valid.
//  load_use_stall
//  - Asserted when ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid and ex_rd_addr equals
//    id_rs1_addr or id_rs2_addr.
//  - Comparison is made even for an unused rs2; this is conservative and allowed.
//  - Forced to 0 while flush=1.
//  Forwarding (per source, independently, for rs1 and rs2)
//  - Source address 0: use the registered data (x0 is never forwarded).
//  - Else if mem_reg_write and mem_rd_addr matches: use mem_result (MEM beats WB).
//  - Else if wb_reg_write and wb_rd_addr matches: use wb_result.
//  - Else: use the registered data.
//  Operand B and store data
//  - alu_rs2 = ex_alu_src ? ex_imm : fwd_rs2.
//  - ex_store_data = fwd_rs2 in all cases.
//  Bubble outputs
//  - When ex_valid=0, ex_reg_write, ex_mem_read and ex_mem_write are 0.
//  - Other fields are don't-care but stay deterministic.
//  Width
//  - Pure selection; no arithmetic in this stage.
// TESTING
//  T1 reset
//  - Assert rst_n=0 mid-cycle with the stage loaded -> all outputs 0 immediately, with no clock edge.
//  T2 pass-through
//  - Drive id_valid=1, rs1_data=5, rs2_data=7, alu_control=0, no hazards.
//  - Next edge -> alu_rs1=5, alu_rs2=7, ex_valid=1.
//  T3 forward priority
//  - EX src rs1=x3; MEM writes x3=0xAA and WB writes x3=0xBB -> alu_rs1=0xAA.
//  - Same, with MEM writing x0 instead -> alu_rs1=0xBB for the x3 source.
//  T4 load-use
//  - EX holds lw x4 (mem_read=1); ID holds add x5,x4,x1 -> load_use_stall=1.
//  - Next edge -> ex_valid=0.
//  - Following edge -> the add is captured.
//  T5 stall refresh
//  - stall=1 for 3 cycles, with WB writing rs1's register (=0x55) during cycle 1 only.
//  - After release -> alu_rs1=0x55.
//  T6 flush vs stall
//  - flush=1 and stall=1 on the same edge -> ex_valid=0, ex_reg_write=0, load_use_stall=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Operand A/B and store data are combinational selections from the registered sources.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [ALUC_W-1:0] id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_result,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   alu_rs1,
    output logic [XLEN-1:0]   alu_rs2,
    output logic [ALUC_W-1:0] alu_control,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    // Registered operand sources that are not themselves ports.
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic              alu_src_q;

    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic              rs1_hit;
    logic              rs2_hit;

    // Forwarding: x0 never forwards, MEM is younger than WB so it wins.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_addr_q != '0) begin
            if (mem_reg_write && (mem_rd_addr == rs1_addr_q)) begin
                fwd_rs1 = mem_result;
            end else if (wb_reg_write && (wb_rd_addr == rs1_addr_q)) begin
                fwd_rs1 = wb_result;
            end
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (rs2_addr_q != '0) begin
            if (mem_reg_write && (mem_rd_addr == rs2_addr_q)) begin
                fwd_rs2 = mem_result;
            end else if (wb_reg_write && (wb_rd_addr == rs2_addr_q)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    assign alu_rs1       = fwd_rs1;
    assign alu_rs2       = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    // rs2 is compared even when the decoded op does not read it; a spare bubble is harmless.
    always_comb begin
        rs1_hit        = (ex_rd_addr == id_rs1_addr);
        rs2_hit        = (ex_rd_addr == id_rs2_addr);
        load_use_stall = 1'b0;
        if (!flush && ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid) begin
            load_use_stall = rs1_hit || rs2_hit;
        end
    end

    // Update priority per edge: flush, then stall, then bubble, then a normal load.
    // During flush/stall the operand data registers track their forwarded values so a
    // result retiring from WB while the stage is held is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            ex_rd_addr   <= '0;
            alu_control  <= '0;
            alu_src_q    <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            rs1_data_q   <= fwd_rs1;
            rs2_data_q   <= fwd_rs2;
        end else if (stall) begin
            rs1_data_q   <= fwd_rs1;
            rs2_data_q   <= fwd_rs2;
        end else if (load_use_stall) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            rs1_addr_q   <= id_rs1_addr;
            rs2_addr_q   <= id_rs2_addr;
            ex_rd_addr   <= id_rd_addr;
            alu_control  <= id_alu_control;
            alu_src_q    <= id_alu_src;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX outputs plus directed
// forwarding, load-use, stall, flush and reset scenarios.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  aluc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clk, rst_n, stall, flush;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_control;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, alu_rs1, alu_rs2, ex_store_data;
  logic [4:0]  alu_control, ex_rd_addr;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
    wb_reg_write  = 1'b0; wb_rd_addr  = '0; wb_result  = '0;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] aluc,
                          input logic src, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = aluc;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  // Model of what EX shows one edge after a clean load with no forwarding active.
  task automatic push_exp(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] aluc, input logic src, input logic rw,
                          input logic mr, input logic mw);
    exp_t e;
    e.valid = v; e.pc = pc; e.rs1 = d1; e.rs2 = src ? imm : d2; e.store = d2;
    e.rd = rd; e.rw = rw & v; e.mr = mr & v; e.mw = mw & v; e.aluc = aluc;
    exp_q.push_back(e);
  endtask

  // scoreboard pop/compare
  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
      check({tag, ".pc"}, ex_pc, e.pc);
      check({tag, ".alu_rs1"}, alu_rs1, e.rs1);
      check({tag, ".alu_rs2"}, alu_rs2, e.rs2);
      check({tag, ".store"}, ex_store_data, e.store);
      check({tag, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
      check({tag, ".ctl"}, {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
            {29'd0, e.rw, e.mr, e.mw});
      check({tag, ".aluc"}, 32'(alu_control), 32'(e.aluc));
    end
  endtask

  initial begin
    logic        v, src, rw, mw;
    logic [4:0]  a1, a2, rd, aluc;
    logic [31:0] pc, d1, d2, imm;

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
    #12;
    check("rst.valid", 32'(ex_valid), 0);
    check("rst.alu_rs1", alu_rs1, 0);
    check("rst.lus", 32'(load_use_stall), 0);
    tick();
    rst_n = 1'b1;

    // T2 pass-through
    drive_id(1, 32'h100, 1, 2, 3, 5, 7, 32'h40, 0, 0, 1, 0, 0);
    push_exp(1, 32'h100, 3, 5, 7, 32'h40, 0, 0, 1, 0, 0);
    tick();
    check_out("t2");
    check("t2.lus", 32'(load_use_stall), 0);

    // Randomised pass-through; loads excluded so no load-use bubble can arise.
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom_range(0, 1)); src = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
      a1 = 5'($urandom_range(0, 31)); a2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); aluc = 5'($urandom_range(0, 31));
      pc = $urandom; d1 = $urandom; d2 = $urandom; imm = $urandom;
      drive_id(v, pc, a1, a2, rd, d1, d2, imm, aluc, src, rw, 0, mw);
      push_exp(v, pc, rd, d1, d2, imm, aluc, src, rw, 0, mw);
      tick();
      check_out($sformatf("rand%0d", i));
    end

    // T3 forward priority
    drive_id(1, 32'h200, 3, 3, 9, 32'h11, 32'h22, 32'h0, 2, 0, 1, 0, 0);
    push_exp(1, 32'h200, 9, 32'h11, 32'h22, 32'h0, 2, 0, 1, 0, 0);
    tick();
    check_out("t3.cap");
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'hAA;
    wb_reg_write  = 1; wb_rd_addr  = 3; wb_result  = 32'hBB;
    #1;
    check("t3.mem_wins", alu_rs1, 32'hAA);
    check("t3.rs2_mem", alu_rs2, 32'hAA);
    check("t3.store_mem", ex_store_data, 32'hAA);
    mem_rd_addr = 0;
    #1;
    check("t3.wb", alu_rs1, 32'hBB);
    check("t3.store_wb", ex_store_data, 32'hBB);
    clear_fwd();
    // x0 source never forwards even when MEM/WB claim to write x0
    drive_id(1, 32'h204, 0, 4, 9, 32'h33, 32'h44, 32'h8, 2, 1, 1, 0, 0);
    push_exp(1, 32'h204, 9, 32'h33, 32'h44, 32'h8, 2, 1, 1, 0, 0);
    tick();
    check_out("t3.x0cap");
    mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'hDEAD;
    wb_reg_write  = 1; wb_rd_addr  = 0; wb_result  = 32'hBEEF;
    #1;
    check("t3.x0", alu_rs1, 32'h33);
    check("t3.imm_sel", alu_rs2, 32'h8);
    clear_fwd();

    // T4 load-use: lw x4 then add x5,x4,x1
    drive_id(1, 32'h300, 1, 0, 4, 32'h1, 32'h0, 32'h10, 0, 1, 1, 1, 0);
    push_exp(1, 32'h300, 4, 32'h1, 32'h0, 32'h10, 0, 1, 1, 1, 0);
    tick();
    check_out("t4.lw");
    drive_id(1, 32'h304, 4, 1, 5, 32'h99, 32'h10, 32'h0, 0, 0, 1, 0, 0);
    #1;
    check("t4.lus", 32'(load_use_stall), 1);
    tick();
    check("t4.bubble.valid", 32'(ex_valid), 0);
    check("t4.bubble.ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    check("t4.lus_clear", 32'(load_use_stall), 0);
    id_rs1_data = 32'h44;
    push_exp(1, 32'h304, 5, 32'h44, 32'h10, 32'h0, 0, 0, 1, 0, 0);
    tick();
    check_out("t4.add");
    // rs2 match also stalls; flush suppresses it; invalid decode never stalls
    drive_id(1, 32'h308, 2, 0, 6, 32'h0, 32'h0, 32'h0, 0, 1, 1, 1, 0);
    push_exp(1, 32'h308, 6, 32'h0, 32'h0, 32'h0, 0, 1, 1, 1, 0);
    tick();
    check_out("t4.lw6");
    drive_id(1, 32'h30c, 2, 6, 7, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0);
    #1;
    check("t4.lus_rs2", 32'(load_use_stall), 1);
    flush = 1;
    #1;
    check("t4.lus_flush", 32'(load_use_stall), 0);
    flush = 0; id_valid = 0;
    #1;
    check("t4.lus_novalid", 32'(load_use_stall), 0);
    tick();

    // T5 stall refresh
    drive_id(1, 32'h400, 7, 0, 8, 32'h10, 32'h0, 32'h0, 3, 0, 1, 0, 0);
    push_exp(1, 32'h400, 8, 32'h10, 32'h0, 32'h0, 3, 0, 1, 0, 0);
    tick();
    check_out("t5.cap");
    stall = 1;
    drive_id(1, 32'h404, 1, 2, 10, 32'h66, 32'h77, 32'h0, 4, 0, 1, 0, 0);
    wb_reg_write = 1; wb_rd_addr = 7; wb_result = 32'h55;
    #1;
    check("t5.fwd", alu_rs1, 32'h55);
    tick();
    clear_fwd();
    #1;
    check("t5.held_data", alu_rs1, 32'h55);
    tick();
    tick();
    check("t5.held_pc", ex_pc, 32'h400);
    check("t5.held_rd", 32'(ex_rd_addr), 8);
    stall = 0;
    #1;
    check("t5.release", alu_rs1, 32'h55);
    push_exp(1, 32'h404, 10, 32'h66, 32'h77, 32'h0, 4, 0, 1, 0, 0);
    tick();
    check_out("t5.next");

    // T6 flush vs stall
    drive_id(1, 32'h500, 0, 0, 9, 32'h0, 32'h0, 32'h0, 0, 1, 1, 1, 0);
    push_exp(1, 32'h500, 9, 32'h0, 32'h0, 32'h0, 0, 1, 1, 1, 0);
    tick();
    check_out("t6.lw");
    drive_id(1, 32'h504, 9, 0, 11, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 0);
    stall = 1; flush = 1;
    #1;
    check("t6.lus", 32'(load_use_stall), 0);
    tick();
    check("t6.valid", 32'(ex_valid), 0);
    check("t6.rw", 32'(ex_reg_write), 0);
    check("t6.mr", 32'(ex_mem_read), 0);
    stall = 0; flush = 0;

    // T1 asynchronous reset mid-cycle with the stage loaded
    drive_id(1, 32'h600, 5, 6, 12, 32'h123, 32'h456, 32'h0, 7, 0, 1, 0, 1);
    push_exp(1, 32'h600, 12, 32'h123, 32'h456, 32'h0, 7, 0, 1, 0, 1);
    tick();
    check_out("t1.loaded");
    #2;
    rst_n = 0;
    #1;
    check("t1.valid", 32'(ex_valid), 0);
    check("t1.pc", ex_pc, 0);
    check("t1.alu_rs1", alu_rs1, 0);
    check("t1.alu_rs2", alu_rs2, 0);
    check("t1.store", ex_store_data, 0);
    check("t1.aluc", 32'(alu_control), 0);
    check("t1.rd", 32'(ex_rd_addr), 0);
    check("t1.ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    check("t1.lus", 32'(load_use_stall), 0);
    tick();
    rst_n = 1;

    check("sb.drained", 32'(exp_q.size()), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
